// File: rtl/key_debounce.sv
// Synchronising debouncer for NUM_KEYS mechanical keys with press/release strobes.
// Optional auto-repeat of key_press while held: define KEY_REPEAT_EN.
module key_debounce #(
  parameter int NUM_KEYS       = 4,
  parameter int DB_CYCLES      = 1000000,
  parameter int CNT_W          = 20,
  parameter bit KEY_ACTIVE_LOW = 1'b1
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 25000000,
  parameter int REPEAT_PERIOD  = 5000000
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  // Synchronisers reset to the released pad level so reset exit never looks like an edge.
  localparam logic [NUM_KEYS-1:0] REL_RAW = KEY_ACTIVE_LOW ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};
  localparam logic [CNT_W-1:0]    DB_LAST = CNT_W'(DB_CYCLES - 1);

`ifdef KEY_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] DLY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PER_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0]   hold_q [NUM_KEYS];
  logic [HOLD_W-1:0]   hold_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] rep_q;
  logic [NUM_KEYS-1:0] rep_d;
`endif

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] s_s;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_q;
  logic [NUM_KEYS-1:0] level_d;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] press_d;
  logic [NUM_KEYS-1:0] release_q;
  logic [NUM_KEYS-1:0] release_d;

  assign s_s = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Per-key qualification: count consecutive cycles the input disagrees with the level.
  always_comb begin
    level_d   = level_q;
    press_d   = {NUM_KEYS{1'b0}};
    release_d = {NUM_KEYS{1'b0}};
`ifdef KEY_REPEAT_EN
    rep_d     = rep_q;
`endif
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (s_s[k] == level_q[k]) begin
        cnt_d[k] = {CNT_W{1'b0}};
      end else if (cnt_q[k] == DB_LAST) begin
        level_d[k]   = s_s[k];
        cnt_d[k]     = {CNT_W{1'b0}};
        press_d[k]   = s_s[k];
        release_d[k] = ~s_s[k];
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
`ifdef KEY_REPEAT_EN
      // Hold timer restarts at every accepted press and is idle while released.
      hold_d[k] = hold_q[k];
      if (!level_q[k] || press_d[k] || release_d[k]) begin
        hold_d[k] = {HOLD_W{1'b0}};
        rep_d[k]  = 1'b0;
      end else if (hold_q[k] == (rep_q[k] ? PER_LAST : DLY_LAST)) begin
        press_d[k] = 1'b1;
        hold_d[k]  = {HOLD_W{1'b0}};
        rep_d[k]   = 1'b1;
      end else begin
        hold_d[k] = hold_q[k] + HOLD_W'(1);
      end
`endif
    end
  end

  // State and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= REL_RAW;
      sync2_q   <= REL_RAW;
      level_q   <= {NUM_KEYS{1'b0}};
      press_q   <= {NUM_KEYS{1'b0}};
      release_q <= {NUM_KEYS{1'b0}};
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= {CNT_W{1'b0}};
      end
`ifdef KEY_REPEAT_EN
      rep_q <= {NUM_KEYS{1'b0}};
      for (int k = 0; k < NUM_KEYS; k++) begin
        hold_q[k] <= {HOLD_W{1'b0}};
      end
`endif
    end else begin
      sync1_q   <= key_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
`ifdef KEY_REPEAT_EN
      rep_q <= rep_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        hold_q[k] <= hold_d[k];
      end
`endif
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: window-based reference model, directed phases plus random bouncing.
module tb_key_debounce;
  localparam int NK = 4;
  localparam int DB = 4;
  localparam int CW = 3;
`ifdef KEY_REPEAT_EN
  localparam int RD = 10;
  localparam int RP = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_raw = 4'b1111;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  always #5 clk = ~clk;

  key_debounce #(
    .NUM_KEYS(NK), .DB_CYCLES(DB), .CNT_W(CW), .KEY_ACTIVE_LOW(1'b1)
`ifdef KEY_REPEAT_EN
    , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: a key flips when the last DB synchronised samples all disagree with its level.
  logic [NK-1:0] m_hist[$];
  logic [NK-1:0] m_level, m_press, m_rel;
  int            m_since[NK];
  int            first_press[NK];
  int            press_cnt[NK];
  logic [NK-1:0] last_rel;

  task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: got %b expected %b (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < DB + 1; i++) m_hist.push_back('0);
    m_level = '0; m_press = '0; m_rel = '0;
    for (int k = 0; k < NK; k++) m_since[k] = 0;
  endtask

  task automatic model_edge(input logic [NK-1:0] raw);
    logic [NK-1:0] flip;
    m_press = '0; m_rel = '0;
    for (int k = 0; k < NK; k++) begin
      flip[k] = 1'b1;
      for (int i = 0; i < DB; i++) if (m_hist[i][k] == m_level[k]) flip[k] = 1'b0;
      if (flip[k]) begin
        if (m_level[k]) m_rel[k] = 1'b1;
        else begin m_press[k] = 1'b1; m_since[k] = 0; end
      end
`ifdef KEY_REPEAT_EN
      else if (m_level[k]) begin
        m_since[k]++;
        if (m_since[k] == RD || (m_since[k] > RD && (m_since[k] - RD) % RP == 0)) m_press[k] = 1'b1;
      end
`endif
    end
    m_level = m_level ^ flip;
    m_hist.push_back(~raw);
    void'(m_hist.pop_front());
  endtask

  task automatic step(input logic [NK-1:0] raw);
    key_raw = raw;
    @(posedge clk);
    cyc++;
    if (!rst) model_edge(raw);
    #1;
    check("level", key_level, m_level);
    check("press", key_press, m_press);
    check("release", key_release, m_rel);
    for (int k = 0; k < NK; k++) begin
      if (key_press[k]) begin
        press_cnt[k]++;
        if (first_press[k] < 0) first_press[k] = cyc;
      end
    end
    if (key_release != '0) last_rel = key_release;
  endtask

  task automatic clear_obs();
    for (int k = 0; k < NK; k++) begin first_press[k] = -1; press_cnt[k] = 0; end
    last_rel = '0;
  endtask

  initial begin
    int base;
    logic [NK-1:0] cur;
    model_reset();
    clear_obs();
    // Power-on reset, then 100 idle cycles with keys released.
    repeat (3) step(4'b1111);
    rst = 1'b0;
    repeat (100) step(4'b1111);
    check_int("idle_no_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

    // Clean press on key 0.
    clear_obs();
    base = cyc;
    repeat (10) step(4'b1110);
    check_int("clean_press_latency", first_press[0] - base, DB + 2);
    check("clean_level", key_level, 4'b0001);

    // Bouncing press on key 1 while key 0 stays held.
    clear_obs();
    repeat (3) step(4'b1100);
    repeat (2) step(4'b1110);
    repeat (3) step(4'b1100);
    repeat (1) step(4'b1110);
    base = cyc;
    repeat (10) step(4'b1100);
    check_int("bounce_latency", first_press[1] - base, DB + 2);
    check_int("bounce_single", press_cnt[1], 1);

    // Keys 2 and 3 pressed, then released on the same edge.
    clear_obs();
    repeat (8) step(4'b0000);
    repeat (8) step(4'b1100);
    check("release_pair", last_rel, 4'b1100);
    check("pair_level", key_level, 4'b0011);

    // Reset pulsed while key 0 is qualifying.
    repeat (8) step(4'b1111);
    clear_obs();
    repeat (4) step(4'b1110);
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_level", key_level, 4'b0000);
    check("async_rst_press", key_press, 4'b0000);
    repeat (2) step(4'b1110);
    rst = 1'b0;
    check_int("no_press_before_rst", press_cnt[0], 0);
    base = cyc;
    repeat (10) step(4'b1110);
    check_int("press_after_rst", first_press[0] - base, DB + 2);

    // Random bouncing on all keys.
    repeat (8) step(4'b1111);
    cur = 4'b1111;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NK; k++) if ($urandom_range(0, 5) == 0) cur[k] = ~cur[k];
      step(cur);
    end

`ifdef KEY_REPEAT_EN
    // Auto-repeat on key 0 held past the repeat delay.
    repeat (12) step(4'b1111);
    clear_obs();
    repeat (21) step(4'b1110);
    repeat (12) step(4'b1111);
    check_int("repeat_count", press_cnt[0], 5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
